// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: single write-port master for the 32x32 register file.
// Merges in-order pipeline writebacks (primary) with long-latency mul/div
// results (secondary). Secondary results wait in a small FIFO. At most one
// register-file write is issued per cycle, from a registered output stage.
// A starvation counter makes sure a waiting FIFO head eventually wins.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   p_valid/p_reg/p_data primary writeback request
//   p_stall              primary not accepted this cycle (upstream holds p_*)
//   s_valid/s_reg/s_data secondary writeback request
//   s_ready              secondary handshake completes on s_valid & s_ready
//   rf_wr/wr_reg/wr_data registered register-file write port
//   pend_mask            combinational mask of writes still in flight
module rf_wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_valid,
  input  logic [4:0]  p_reg,
  input  logic [31:0] p_data,
  output logic        p_stall,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [4:0]  s_reg,
  input  logic [31:0] s_data,
  output logic        rf_wr,
  output logic [4:0]  wr_reg,
  output logic [31:0] wr_data,
  output logic [31:0] pend_mask
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned CtrW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]      fifo_reg_q  [DEPTH];
  logic [31:0]     fifo_data_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CtrW-1:0] ctr_q, ctr_d;
  logic            rf_wr_q, rf_wr_d;
  logic [4:0]      wr_reg_q, wr_reg_d;
  logic [31:0]     wr_data_q, wr_data_d;

  logic push;
  logic pop;
  logic fifo_empty;
  logic starved;

  assign fifo_empty = (count_q == '0);
  assign starved    = !fifo_empty && (ctr_q == CtrW'(STARVE_LIMIT));
  assign s_ready    = !rst && (count_q != CntW'(DEPTH));
  // A write to r0 is a no-op: complete the handshake but keep it out of the FIFO.
  assign push       = s_valid && s_ready && (s_reg != 5'd0);

  // Slot selection: starved head, then primary, then any queued head.
  always_comb begin
    pop       = 1'b0;
    p_stall   = 1'b0;
    rf_wr_d   = 1'b0;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    ctr_d     = ctr_q;

    if (starved) begin
      p_stall = 1'b1;
      pop     = 1'b1;
      ctr_d   = '0;
    end else if (p_valid && (p_reg != 5'd0)) begin
      rf_wr_d   = 1'b1;
      wr_reg_d  = p_reg;
      wr_data_d = p_data;
      if (!fifo_empty && (ctr_q != CtrW'(STARVE_LIMIT))) begin
        ctr_d = ctr_q + CtrW'(1);
      end
    end else if (!fifo_empty) begin
      // Also covers a primary to r0, which is accepted and dropped.
      pop   = 1'b1;
      ctr_d = '0;
    end

    if (pop) begin
      rf_wr_d   = 1'b1;
      wr_reg_d  = fifo_reg_q[rd_ptr_q];
      wr_data_d = fifo_data_q[rd_ptr_q];
    end

    if (fifo_empty) begin
      ctr_d = '0;
    end

    // Pop reads the entry at rd_ptr before any same-cycle push lands.
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);

    if (rst) begin
      p_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ctr_q     <= '0;
      rf_wr_q   <= 1'b0;
      wr_reg_q  <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ctr_q     <= ctr_d;
      rf_wr_q   <= rf_wr_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg_q[wr_ptr_q]  <= s_reg;
      fifo_data_q[wr_ptr_q] <= s_data;
    end
  end

  always_comb begin
    logic [PtrW-1:0] idx;
    pend_mask = 32'd0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PtrW'(i);
      if (CntW'(i) < count_q) begin
        pend_mask = pend_mask | (32'd1 << fifo_reg_q[idx]);
      end
    end
    if (rf_wr_q) begin
      pend_mask = pend_mask | (32'd1 << wr_reg_q);
    end
    pend_mask[0] = 1'b0;
    if (rst) begin
      pend_mask = 32'd0;
    end
  end

  assign rf_wr   = rf_wr_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_valid = 1'b0;
  logic [4:0]  p_reg = 5'd0;
  logic [31:0] p_data = 32'd0;
  logic        p_stall;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [4:0]  s_reg = 5'd0;
  logic [31:0] s_data = 32'd0;
  logic        rf_wr;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [31:0] pend_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_valid   (p_valid),
    .p_reg     (p_reg),
    .p_data    (p_data),
    .p_stall   (p_stall),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_reg     (s_reg),
    .s_data    (s_data),
    .rf_wr     (rf_wr),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .pend_mask (pend_mask)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    p_valid = 1'b0;
    p_reg   = 5'd0;
    p_data  = 32'd0;
    s_valid = 1'b0;
    s_reg   = 5'd0;
    s_data  = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Check the registered write port: {rf_wr, wr_reg}.
  task automatic check_wr(input string tag, input logic en, input logic [4:0] r);
    check_eq(tag, {26'd0, rf_wr, wr_reg}, {26'd0, en, r});
  endtask

  initial begin
    // 1: reset state
    rst = 1'b1;
    tick();
    tick();
    check_eq("t1 rf_wr in rst", {31'd0, rf_wr}, 32'd0);
    check_eq("t1 s_ready in rst", {31'd0, s_ready}, 32'd0);
    check_eq("t1 pend_mask in rst", pend_mask, 32'd0);
    rst = 1'b0;
    settle();
    check_eq("t1 s_ready after rst", {31'd0, s_ready}, 32'd1);

    // 2: single primary write, one-cycle latency
    p_valid = 1'b1; p_reg = 5'd5; p_data = 32'hDEAD_BEEF;
    tick();
    idle();
    check_wr("t2 wr", 1'b1, 5'd5);
    check_eq("t2 wr_data", wr_data, 32'hDEAD_BEEF);
    tick();
    check_wr("t2 idle", 1'b0, 5'd5);

    // 3: fill FIFO with regs 8..11 while the primary (reg 2) holds the slot
    do_reset();
    p_valid = 1'b1; p_reg = 5'd2; p_data = 32'h2222_0000;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_reg  = 5'(8 + i);
      s_data = 32'hA000_0000 + 32'(i);
      settle();
      check_eq("t3 s_ready filling", {31'd0, s_ready}, 32'd1);
      tick();
    end
    idle();
    settle();
    check_eq("t3 s_ready full", {31'd0, s_ready}, 32'd0);
    check_eq("t3 pend full", pend_mask, 32'h0000_0F04);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_wr("t3 drain", 1'b1, 5'(8 + i));
      check_eq("t3 drain data", wr_data, 32'hA000_0000 + 32'(i));
    end
    check_eq("t3 s_ready empty", {31'd0, s_ready}, 32'd1);
    tick();
    check_wr("t3 done", 1'b0, 5'd11);

    // 4: starvation of reg 9 behind a continuous primary stream to reg 3
    do_reset();
    p_valid = 1'b1; p_reg = 5'd3; p_data = 32'h3333_3333;
    s_valid = 1'b1; s_reg = 5'd9; s_data = 32'h9999_0009;
    settle();
    check_eq("t4 first no stall", {31'd0, p_stall}, 32'd0);
    tick();
    s_valid = 1'b0; s_reg = 5'd0;
    for (int k = 0; k < 8; k++) begin
      settle();
      check_eq("t4 no stall", {31'd0, p_stall}, 32'd0);
      tick();
      check_wr("t4 prim", 1'b1, 5'd3);
    end
    settle();
    check_eq("t4 stall", {31'd0, p_stall}, 32'd1);
    check_eq("t4 pend", pend_mask, 32'h0000_0208);
    tick();
    check_wr("t4 starved write", 1'b1, 5'd9);
    check_eq("t4 starved data", wr_data, 32'h9999_0009);
    settle();
    check_eq("t4 resume", {31'd0, p_stall}, 32'd0);
    tick();
    check_wr("t4 prim again", 1'b1, 5'd3);
    idle();

    // 5: r0 writes are dropped; a dropped primary frees the slot for the FIFO
    do_reset();
    s_valid = 1'b1; s_reg = 5'd20; s_data = 32'h0000_0020;
    tick();
    check_wr("t5 no same-cycle pop", 1'b0, 5'd0);
    s_valid = 1'b0;
    p_valid = 1'b1; p_reg = 5'd0; p_data = 32'hFFFF_FFFF;
    settle();
    check_eq("t5 r0 no stall", {31'd0, p_stall}, 32'd0);
    tick();
    check_wr("t5 head via free slot", 1'b1, 5'd20);
    s_valid = 1'b1; s_reg = 5'd0; s_data = 32'h1234_5678;
    settle();
    check_eq("t5 r0 s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    check_wr("t5 r0 dropped", 1'b0, 5'd20);
    idle();
    tick();
    check_wr("t5 still idle", 1'b0, 5'd20);
    check_eq("t5 pend", pend_mask, 32'd0);

    // 6: push+pop same cycle keeps order; reset mid-drain empties the FIFO
    do_reset();
    p_valid = 1'b1; p_reg = 5'd2; p_data = 32'h2222_0000;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_reg = 5'(12 + i);
      tick();
    end
    idle();
    settle();
    check_eq("t6 pend full", pend_mask, 32'h0000_F004);
    tick();
    check_wr("t6 pop 12", 1'b1, 5'd12);
    s_valid = 1'b1; s_reg = 5'd16; s_data = 32'h0000_0016;
    settle();
    check_eq("t6 s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0; s_reg = 5'd0;
    check_wr("t6 pop 13", 1'b1, 5'd13);
    check_eq("t6 pend after push+pop", pend_mask, 32'h0001_E000);
    tick();
    check_wr("t6 pop 14", 1'b1, 5'd14);
    tick();
    check_wr("t6 pop 15", 1'b1, 5'd15);
    check_eq("t6 pend mid", pend_mask, 32'h0001_8000);
    rst = 1'b1;
    settle();
    check_eq("t6 rst s_ready", {31'd0, s_ready}, 32'd0);
    check_eq("t6 rst p_stall", {31'd0, p_stall}, 32'd0);
    check_eq("t6 rst pend", pend_mask, 32'd0);
    tick();
    rst = 1'b0;
    check_wr("t6 after rst", 1'b0, 5'd0);
    settle();
    check_eq("t6 pend after rst", pend_mask, 32'd0);
    check_eq("t6 s_ready after rst", {31'd0, s_ready}, 32'd1);
    tick();
    check_wr("t6 discarded", 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
